// File: rtl/serial_shifter_if.sv
// serial_shifter_if: request/result bundle between the core's execute-stage
// control and the iterative shift unit.
//
// Handshake (start/done, no ready):
//   - The master raises start for one or more cycles. The slave samples
//     start, a, shamt and typ on a rising clock edge only while it is
//     accepting, i.e. while it is idle or presenting done. At any other
//     time start and the operands are ignored.
//   - busy is high while an accepted request is being shifted.
//   - done is a one-cycle pulse. r is valid from that cycle and holds until
//     the next request completes.
//
// Signals:
//   start  master->slave  request strobe
//   a      master->slave  operand (rs1)
//   shamt  master->slave  shift amount
//   typ    master->slave  {IR[30], IR[14]}: 00 SLL, 01 SRL, 11 SRA, 10 reserved
//                         ("type" is a reserved word, hence typ)
//   busy   slave->master  request in progress
//   done   slave->master  completion pulse
//   r      slave->master  result
interface serial_shifter_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [XLEN-1:0] a;
  logic [4:0]      shamt;
  logic [1:0]      typ;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] r;

  modport master (
    output start, a, shamt, typ,
    input  busy, done, r
  );

  modport slave (
    input  start, a, shamt, typ,
    output busy, done, r
  );
endinterface

// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle RV32I shift unit (SLL/SRL/SRA). Each request
// shifts one bit position per clock instead of using a barrel array.
// Latency is shamt+2 cycles from the accepting edge to done.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   bus          serial_shifter_if.slave (start/a/shamt/typ in, busy/done/r out)
//   dbg_state_o  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
module serial_shifter #(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_shifter_if.slave        bus,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] r_q, r_d;
  logic            accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      r_q     <= r_d;
    end
  end

  // A request is accepted from IDLE or straight out of DONE, which gives
  // back-to-back throughput without an idle cycle.
  assign accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    r_d     = r_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
          case (op_q)
            2'b00:   acc_d = {acc_q[XLEN-2:0], 1'b0};
            2'b01:   acc_d = {1'b0, acc_q[XLEN-1:1]};
            // acc[MSB] still holds the original sign bit on every step.
            2'b11:   acc_d = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_d = acc_q;
          endcase
        end else begin
          r_d     = acc_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Loading overrides the IDLE/DONE transitions above.
    if (accept) begin
      state_d = S_SHIFT;
      op_d    = bus.typ;
      if (bus.typ == 2'b10) begin
        // Reserved encoding: result 0 with zero shift steps.
        acc_d = '0;
        cnt_d = 5'd0;
      end else begin
        acc_d = bus.a;
        cnt_d = bus.shamt;
      end
    end
  end

  // Status is decoded from registered state only; no path from start.
  assign bus.busy    = (state_q == S_SHIFT);
  assign bus.done    = (state_q == S_DONE);
  assign bus.r       = r_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_shifter.sv
module tb_serial_shifter;

  localparam int XLEN = 32;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] exp_q[$];

  serial_shifter_if #(.XLEN(XLEN)) bus ();

  serial_shifter #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [XLEN-1:0] got,
                     input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain RV32I shift semantics.
  function automatic logic [XLEN-1:0] ref_shift(input logic [XLEN-1:0] a,
                                                input int s, input logic [1:0] t);
    case (t)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b11:   return XLEN'($signed(a) >>> s);
      default: return '0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1. Presents a request, lets the accepting edge pass and
  // waits for done. Returns the result, the latency (cycles from the accepting
  // edge to the done cycle) and the number of busy cycles seen. With poke set,
  // start is pulsed with junk operands while the unit is busy.
  task automatic do_req(input logic [XLEN-1:0] a, input logic [4:0] s,
                        input logic [1:0] t, input bit poke,
                        output logic [XLEN-1:0] r, output int lat,
                        output int bc);
    bus.start = 1'b1;
    bus.a     = a;
    bus.shamt = s;
    bus.typ   = t;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.shamt = 5'($urandom_range(0, 31));
    bus.typ   = 2'($urandom_range(0, 3));
    lat = 1;
    bc  = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bc++;
      bus.start = (poke && lat == 3);
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    r = bus.r;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Full directed request with result/latency/busy checks, followed by one
  // idle cycle to confirm done is a single-cycle pulse.
  task automatic directed(input string tag, input logic [XLEN-1:0] a,
                          input logic [4:0] s, input logic [1:0] t,
                          input logic [XLEN-1:0] exp_r, input bit poke);
    logic [XLEN-1:0] r;
    int lat, bc;
    int exp_lat;
    exp_lat = (t == 2'b10) ? 2 : int'(s) + 2;
    do_req(a, s, t, poke, r, lat, bc);
    chk({tag, "_r"},    r, exp_r);
    chk({tag, "_lat"},  XLEN'(lat), XLEN'(exp_lat));
    chk({tag, "_busy"}, XLEN'(bc),  XLEN'(exp_lat - 1));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, XLEN'(bus.done), '0);
    chk({tag, "_r_hold"},     bus.r, exp_r);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [XLEN-1:0] r1, r2;
    int lat, bc, seen;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.shamt = '0;
    bus.typ   = '0;
    rst       = 1'b1;
    #12;
    chk("rst_busy",  XLEN'(bus.busy),  '0);
    chk("rst_done",  XLEN'(bus.done),  '0);
    chk("rst_r",     bus.r,            '0);
    chk("rst_state", XLEN'(dbg_state), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic SLL / SRL
    directed("sll4", 32'h8000_0001, 5'd4, 2'b00, 32'h0000_0010, 1'b0);
    directed("srl4", 32'h8000_0001, 5'd4, 2'b01, 32'h0800_0000, 1'b0);

    // SRA extremes
    directed("sra31_neg", 32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF, 1'b0);
    directed("sra31_pos", 32'h7FFF_FFFF, 5'd31, 2'b11, 32'h0000_0000, 1'b0);

    // Zero shift, each valid type
    directed("zero_sll", 32'hDEAD_BEEF, 5'd0, 2'b00, 32'hDEAD_BEEF, 1'b0);
    directed("zero_srl", 32'hDEAD_BEEF, 5'd0, 2'b01, 32'hDEAD_BEEF, 1'b0);
    directed("zero_sra", 32'hDEAD_BEEF, 5'd0, 2'b11, 32'hDEAD_BEEF, 1'b0);

    // Reserved type
    directed("resv", 32'hFFFF_FFFF, 5'd7, 2'b10, 32'h0000_0000, 1'b0);

    // start pulsed while busy is ignored
    directed("poke", 32'h1234_5678, 5'd10, 2'b01, 32'h0004_8D15, 1'b1);

    // Back-to-back: second start lands in the DONE cycle of the first
    do_req(32'h8000_0001, 5'd4, 2'b00, 1'b0, r1, lat, bc);
    chk("b2b_first_r", r1, 32'h0000_0010);
    chk("b2b_first_done", XLEN'(bus.done), 32'd1);
    bus.start = 1'b1;
    bus.a     = 32'hF000_0000;
    bus.shamt = 5'd8;
    bus.typ   = 2'b01;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_busy_next", XLEN'(bus.busy), 32'd1);
    chk("b2b_done_next", XLEN'(bus.done), '0);
    lat = 1;
    seen = 0;
    while (!bus.done && lat < 100) begin
      if (bus.r !== 32'h0000_0010) seen++;
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_r_held", XLEN'(seen), '0);
    chk("b2b_second_r",   bus.r, 32'h00F0_0000);
    chk("b2b_second_lat", XLEN'(lat), 32'd10);
    idle_cycles(2);

    // Reset mid-operation
    bus.start = 1'b1;
    bus.a     = 32'h0000_0001;
    bus.shamt = 5'd20;
    bus.typ   = 2'b00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idle_cycles(4);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy",  XLEN'(bus.busy),  '0);
    chk("mid_rst_done",  XLEN'(bus.done),  '0);
    chk("mid_rst_r",     bus.r,            '0);
    chk("mid_rst_state", XLEN'(dbg_state), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done || bus.busy) seen++;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_done", XLEN'(seen), '0);
    directed("after_rst", 32'h0000_0001, 5'd20, 2'b00, 32'h0010_0000, 1'b0);

    // Randomized requests with random gaps (gap 0 = start in DONE cycle)
    for (int n = 0; n < 1000; n++) begin
      logic [XLEN-1:0] ra;
      logic [4:0]      rs;
      logic [1:0]      rt;
      int              exp_lat;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rs = 5'd0;
        1: rs = 5'd31;
        default: rs = 5'($urandom_range(0, 31));
      endcase
      rt = 2'($urandom_range(0, 3));
      exp_q.push_back(ref_shift(ra, int'(rs), rt));
      exp_lat = (rt == 2'b10) ? 2 : int'(rs) + 2;
      do_req(ra, rs, rt, ($urandom_range(0, 7) == 0), r1, lat, bc);
      r2 = exp_q.pop_front();
      chk("rand_r",   r1, r2);
      chk("rand_lat", XLEN'(lat), XLEN'(exp_lat));
      idle_cycles($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_shifter.md
# serial_shifter

Multi-cycle RV32I shift unit for the team's multicycle core variant. It accepts one shift request per start/done transaction and computes SLL/SRL/SRA iteratively, one bit position per clock, in place of a 32-bit barrel array. It sits beside the ALU in the execute stage. The core's control FSM stalls on `busy` and captures `r` when `done` pulses.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; `shamt` width is fixed at 5 for XLEN=32.

Ports:
- `clk`  in  1  single system clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request strobe; sampled on rising `clk` when the unit is accepting (IDLE or DONE)
- `a`  in  XLEN  operand (rs1), captured with `start`
- `shamt`  in  5  shift amount, captured with `start`
- `type`  in  2  {IR[30], IR[14]}: 00 SLL, 01 SRL, 11 SRA, 10 reserved (result 0); captured with `start`
- `busy`  out  1  high while a request is being shifted
- `done`  out  1  one-cycle pulse; `r` is valid from this cycle onward
- `r`  out  XLEN  result; held until the next completed request

## Operation
- Internal state: FSM {IDLE, SHIFT, DONE}, working register `acc[XLEN-1:0]`, counter `cnt[4:0]`, latched `op[1:0]`.
- IDLE or DONE with `start`=1 at the edge:
  - `acc`←`a`, `op`←`type`, `cnt`←`shamt`, next state SHIFT.
  - If `type`=10, then `acc`←0 and `cnt`←0.
- SHIFT:
  - If `cnt`≠0, each edge shifts `acc` by one and decrements `cnt`:
    - 00: `acc`←{acc[30:0],0}
    - 01: `acc`←{0,acc[31:1]}
    - 11: `acc`←{acc[31],acc[31:1]}
  - If `cnt`=0, next edge: `r`←`acc`, state DONE.
- DONE:
  - With `start`=0: next state IDLE.
  - With `start`=1: the request is accepted exactly as from IDLE (back-to-back throughput).
- `start` in SHIFT is ignored. No queuing. Inputs are don't-care outside the accepting edge.
- `busy` = (state==SHIFT). `done` = (state==DONE). Both are decoded from registered state with no combinational path from `start`.
- `r` changes only on the SHIFT→DONE edge, otherwise it holds.
- SRA sign replication uses the original `a[31]`, preserved in `acc[31]` on every step.
- Reset (async, any state, including mid-shift): state IDLE, `acc`=0, `cnt`=0, `op`=00, `r`=0, `busy`=0, `done`=0. The in-flight request is discarded and no `done` is produced for it.

## Timing
- Request accepted at edge E0. Cycle after E0: `busy`=1.
- Shifting occupies edges E1..E(shamt). Edge E(shamt+1) moves to DONE.
- `done`=1 and `r` valid in the cycle after E(shamt+1). Latency is shamt+2 cycles:
  - shamt=0 → 2
  - shamt=31 → 33
  - reserved type → 2
- `busy` is high for exactly shamt+1 cycles per request.
- `done` is high exactly 1 cycle, unless a new `start` lands in that DONE cycle. In that case `busy` rises the next cycle and `r` holds the old result until the new completion.
- Max throughput is one request per shamt+2 cycles. There is no idle gap when `start` is asserted in the DONE cycle.
- `rst` deassertion: first acceptable `start` is at the first rising edge after release.

## Test plan
- Reset mid-operation: start SLL a=0x0000_0001 shamt=20, assert `rst` at cycle 5 → `busy`/`done`/`r` go 0 immediately (asynchronously). No `done` follows. A new request after release completes normally.
- Basic SLL/SRL: a=0x8000_0001, SLL shamt=4 → r=0x0000_0010, done 6 cycles after start. SRL shamt=4 → r=0x0800_0000.
- SRA sign fill and extremes:
  - a=0x8000_0000, SRA shamt=31 → r=0xFFFF_FFFF after 33 cycles, `busy` high 32 cycles.
  - a=0x7FFF_FFFF, SRA shamt=31 → r=0.
- Zero shift and reserved type:
  - a=0xDEAD_BEEF, shamt=0, any valid type → r=0xDEAD_BEEF, done 2 cycles after start.
  - type=10, a=0xFFFF_FFFF, shamt=7 → r=0, done after 2 cycles.
- Handshake corners:
  - `start` pulsed while busy → ignored, result unchanged.
  - `start` held during DONE with SRL a=0xF000_0000 shamt=8 → second request accepted without IDLE cycle. Second r=0x00F0_0000 and `r` holds the first result until the second `done`.
- Randomized (≥1000 requests, random gaps) vs. reference model a<<s, a>>s, $signed(a)>>>s → exact match and latency=shamt+2 every request.
